// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Optional leading-zero blanking is selected with the BCD_LZ_BLANK_EN macro.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam logic [3:0] DIGIT_MAX   = 4'h9;

    // Counter must hold BIN_W itself, not just BIN_W-1.
    function automatic int cnt_w(input int binW);
        return $clog2(binW + 1);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit correction step of the shift-and-add-3 algorithm:
// a digit of 5 or more gets 3 added, with no carry out of the nibble.
module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock, with a held output register.
// Define BCD_LZ_BLANK_EN to replace leading zero digits with the blank code.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int CW = cnt_w(BIN_W);
    localparam int SW = 4 * (DIGITS + 1);

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [BIN_W-1:0]      shift_q;
    logic [SW-1:0]         scratch_q;
    logic [SW-1:0]         scratchAdj;
    logic [4*DIGITS-1:0]   bcd_q;
    logic [4*DIGITS-1:0]   bcd_d;
    logic                  ovf_q;
    logic                  ovf_d;
    logic                  busy_q;
    logic                  done_q;

    // One add-3 corrector per scratch digit, including the overflow digit.
    for (genvar g = 0; g < DIGITS + 1; g++) begin : gAdj
        bcd_digit_adj uAdj (
            .digit_i (scratch_q[4*g +: 4]),
            .digit_o (scratchAdj[4*g +: 4])
        );
    end

    assign ovf_d = (scratch_q[4*DIGITS +: 4] != 4'd0);

    always_comb begin
        bcd_d = scratch_q[4*DIGITS-1:0];
        if (ovf_d) begin
            for (int i = 0; i < DIGITS; i++) bcd_d[4*i +: 4] = DIGIT_MAX;
        end
`ifdef BCD_LZ_BLANK_EN
        else begin
            // Blank from the top down until the first non-zero digit; the LSD always shows.
            logic leading;
            leading = 1'b1;
            for (int i = DIGITS - 1; i > 0; i--) begin
                if (leading && (bcd_d[4*i +: 4] == 4'd0)) bcd_d[4*i +: 4] = DIGIT_BLANK;
                else                                      leading = 1'b0;
            end
        end
`endif
    end

    // busy stays high through the done cycle; start is only honoured in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (start) begin
                        state_q   <= ST_SHIFT;
                        busy_q    <= 1'b1;
                        shift_q   <= bin;
                        scratch_q <= '0;
                        cnt_q     <= CW'(BIN_W);
                    end
                end
                ST_SHIFT: begin
                    {scratch_q, shift_q} <= {scratchAdj, shift_q} << 1;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    bcd_q   <= bcd_d;
                    ovf_q   <= ovf_d;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule
